pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch sequencer that owns the program counter register and the next-PC selection.
- Issues one instruction-memory request at a time, buffers the returned instruction in a single-entry skid register and presents it to decode with valid/ready.
- Handles redirects from execute (branch/jump target), halts and sequential PC+4 stepping.
- Sits between the instruction memory port and the decode stage.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, target on a misaligned redirect (used only when PC_TRAP_EN is defined).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  request to instruction memory.
- imem_addr  output  XLEN  request address; equals current PC.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; one per granted request, at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  instruction buffer holds a valid instruction.
- if_instr  output  32  buffered instruction.
- if_pc  output  XLEN  address of buffered instruction.
- id_ready  input  1  decode accepts; transfer when if_valid && id_ready.
- redirect_valid  input  1  single-cycle redirect strobe from execute.
- redirect_target  input  XLEN  new PC.
- halt  input  1  level; suppresses new requests.
- pc_o  output  XLEN  current fetch PC (next address to request).

Behaviour:
- Reset (async, active-high): pc=RESET_VEC, state=IDLE, kill=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0. pc_o=RESET_VEC.
- States: IDLE, REQ, WAIT.
- IDLE → REQ on the first clock after reset deasserts. No request is issued in IDLE.
- REQ:
  - imem_req = !halt && (!if_valid || id_ready). imem_addr = pc.
  - On req && gnt → WAIT. Otherwise stay in REQ.
- WAIT: imem_req=0. On rvalid:
  - if kill=1: discard data, clear kill.
  - else: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4.
  - → REQ either way.
- Single outstanding request; no second request until rvalid returns. The buffer is guaranteed free on return because req is only issued when the buffer is empty or being drained.
- Buffer: if_valid clears on transfer (if_valid && id_ready) unless reloaded the same cycle. Data is held stable while if_valid && !id_ready.
- Sequential step wraps modulo 2^XLEN: 32'hFFFF_FFFC+4 → 0.
- Redirect has highest priority, in any state except IDLE:
  - pc<=redirect_target with bits[1:0] forced to 0.
  - if_valid<=0; a buffered instruction is flushed even if id_ready is high that cycle (the transfer still counts at decode; decode must ignore it per pipeline flush).
  - In WAIT, or REQ with gnt the same cycle: kill<=1, next state WAIT. The stale response is discarded and the next request uses the target.
  - In WAIT with rvalid the same cycle: data discarded, no kill set, → REQ.
- Redirect in IDLE is ignored.
- Halt: blocks new requests only. An outstanding WAIT completes normally and the buffer still drains. Deasserting halt resumes at the current pc.
- Reset mid-operation returns everything to reset values immediately. A late rvalid after reset is ignored (state IDLE/REQ ignores rvalid).

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined:
  - Adds output port trap_o (1 bit).
  - A redirect with redirect_target[1:0] != 0 loads pc<=TRAP_VEC instead of the target and pulses trap_o high for exactly one cycle (the cycle after the redirect).
  - Flush/kill rules are identical to a normal redirect. trap_o resets to 0.
- Undefined: no trap_o port; low two bits are silently cleared.

Test Plan:
- Reset release, gnt and rvalid 1 cycle after each req, id_ready=1 → imem_addr sequence 0,4,8,12; if_pc matches; if_instr equals returned words.
- id_ready=0 with buffer full → imem_req stays 0 and if_instr is held. Raise id_ready → transfer happens and req is reasserted in the same cycle.
- Redirect to 32'h40 while in WAIT → stale rvalid discarded (if_valid stays 0), next imem_addr=32'h40, kill cleared.
- Redirect to 32'h80 with buffer valid → if_valid drops next cycle, next request at 32'h80.
- halt=1 during WAIT → response lands in buffer, no further req. halt=0 → req at pc+4. Also preload pc near 32'hFFFF_FFFC via redirect → next address 0.
- PC_TRAP_EN: redirect to 32'h42 → pc=32'h100, trap_o high for 1 cycle. Without macro → next req at 32'h40.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Purpose     : fetch sequencer; owns the PC, issues one imem request at a time, holds the reply in a 1-entry buffer for decode.
// Latency     : imem_req is combinational from state; an instruction reaches if_valid the cycle after imem_rvalid.
// Backpressure: no new request while the buffer is full and decode is stalled (id_ready=0) or while halt is high.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   imem_req/addr/gnt     request channel to instruction memory (addr is always the current PC)
//   imem_rvalid/rdata     response channel, exactly one response per granted request
//   if_valid/instr/pc     single-entry instruction buffer presented to decode
//   id_ready              decode accepts the buffered instruction
//   redirect_valid/target one-cycle PC redirect from execute (low two bits cleared)
//   halt                  level; blocks new requests, in-flight request still completes
//   pc_o                  current fetch PC
//   trap_o                only with PC_TRAP_EN: one-cycle pulse after a misaligned redirect
//
// Build option: define PC_TRAP_EN to send misaligned redirects to TRAP_VEC and add trap_o.
module pc_fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
  output logic [XLEN-1:0] pc_o
`ifdef PC_TRAP_EN
  ,
  output logic            trap_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            kill, kill_nxt;
  logic            if_valid_nxt;
  logic [31:0]     if_instr_nxt;
  logic [XLEN-1:0] if_pc_nxt;

  logic            redir;
  logic            accept;
  logic            resp;
  logic [XLEN-1:0] redir_pc;

  // Redirects are only honoured once the sequencer has left IDLE.
  assign redir = redirect_valid && (state != S_IDLE);

`ifdef PC_TRAP_EN
  logic misaligned;
  assign misaligned = (redirect_target[1:0] != 2'b00);
  assign redir_pc   = misaligned ? TRAP_VEC : {redirect_target[XLEN-1:2], 2'b00};
`else
  // The low target bits are dropped on purpose: instructions are word aligned.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^redirect_target[1:0];
  assign redir_pc        = {redirect_target[XLEN-1:2], 2'b00};
`endif

  assign imem_addr = pc;
  assign pc_o      = pc;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    kill_nxt     = kill;
    if_valid_nxt = if_valid;
    if_instr_nxt = if_instr;
    if_pc_nxt    = if_pc;
    imem_req     = 1'b0;
    accept       = 1'b0;
    resp         = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // Only request when the reply is certain to find the buffer free.
        imem_req = !halt && (!if_valid || id_ready);
        accept   = imem_req && imem_gnt;
        if (accept) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        resp = imem_rvalid;
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Decode drains the buffer; a same-cycle load below overrides this.
    if (if_valid && id_ready) if_valid_nxt = 1'b0;

    if (resp) begin
      kill_nxt = 1'b0;
      // A killed reply belongs to a path that was redirected away from.
      if (!kill && !redir) begin
        if_valid_nxt = 1'b1;
        if_instr_nxt = imem_rdata;
        if_pc_nxt    = pc;
        pc_nxt       = pc + XLEN'(4);
      end
    end

    if (redir) begin
      pc_nxt       = redir_pc;
      if_valid_nxt = 1'b0;
      // Any request still in flight after this edge returns stale data.
      if ((state == S_WAIT && !imem_rvalid) || accept) kill_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_VEC;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      kill     <= kill_nxt;
      if_valid <= if_valid_nxt;
      if_instr <= if_instr_nxt;
      if_pc    <= if_pc_nxt;
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) trap_o <= 1'b0;
    else       trap_o <= redir && misaligned;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic [31:0] pc_o;
`ifdef PC_TRAP_EN
  logic        trap_o;
`endif

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt(halt), .pc_o(pc_o)
`ifdef PC_TRAP_EN
    , .trap_o(trap_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: fetch running?, one request in flight (maybe stale), buffer contents.
  bit          m_run, m_out, m_stale, m_bv, m_trap;
  logic [31:0] m_pc, m_bi, m_bpc;

  // Memory responder.
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_dat;
  int          min_dly = 1, max_dly = 1;
  bit          use_pattern = 1'b1;
  bit          spur_en = 1'b0;

  logic [31:0] acc_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return m_run && !m_out && !halt && (!m_bv || id_ready);
  endfunction

  task automatic m_reset();
    m_run = 0; m_out = 0; m_stale = 0; m_bv = 0; m_trap = 0;
    m_pc = RESET_VEC; m_bi = 0; m_bpc = 0;
    pend = 0;
  endtask

  task automatic check_outputs();
    chk("imem_req", imem_req, m_req());
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_o", pc_o, m_pc);
    chk("if_valid", if_valid, m_bv);
    if (m_bv) begin
      chk("if_instr", if_instr, m_bi);
      chk("if_pc", if_pc, m_bpc);
    end
`ifdef PC_TRAP_EN
    chk("trap_o", trap_o, m_trap);
`endif
  endtask

  task automatic m_step();
    bit          acc, resp, bv_n, out_n, stale_n;
    logic [31:0] pc_n;
    if (!m_run) begin
      m_run = 1;
      return;
    end
    acc     = m_req() && imem_gnt;
    resp    = m_out && imem_rvalid;
    bv_n    = m_bv && !id_ready;
    pc_n    = m_pc;
    out_n   = m_out;
    stale_n = m_stale;
    if (resp) begin
      out_n = 0; stale_n = 0; pend = 0;
      if (!m_stale && !redirect_valid) begin
        bv_n = 1; m_bi = imem_rdata; m_bpc = m_pc; pc_n = m_pc + 32'd4;
      end
    end
    if (acc) begin
      out_n = 1; stale_n = 0; pend = 1;
      pend_cnt = $urandom_range(max_dly, min_dly);
      pend_dat = use_pattern ? {16'hC0DE, m_pc[15:0]} : $urandom;
    end
    m_trap = 0;
    if (redirect_valid) begin
      bv_n    = 0;
      stale_n = out_n;
      pc_n    = redirect_target & 32'hFFFF_FFFC;
`ifdef PC_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        pc_n = TRAP_VEC; m_trap = 1;
      end
`endif
    end
    m_pc = pc_n; m_bv = bv_n; m_out = out_n; m_stale = stale_n;
  endtask

  // One clock: drive at negedge, compare 1ns later, advance the model at posedge.
  task automatic cyc(input bit h, input bit rdy, input bit g, input bit rv, input logic [31:0] tgt);
    @(negedge clk);
    halt = h; id_ready = rdy; imem_gnt = g; redirect_valid = rv; redirect_target = tgt;
    imem_rvalid = 0; imem_rdata = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1; imem_rdata = pend_dat;
      end
    end else if (spur_en && !m_out && $urandom_range(7, 0) == 0) begin
      imem_rvalid = 1;
    end
    #1;
    check_outputs();
    if (imem_req && imem_gnt) acc_log.push_back(imem_addr);
    @(posedge clk);
    m_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; imem_rvalid = 0; imem_gnt = 0; redirect_valid = 0;
    m_reset();
    #1;
    chk("rst imem_req", imem_req, 1'b0);
    chk("rst if_valid", if_valid, 1'b0);
    chk("rst if_instr", if_instr, 32'h0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst pc_o", pc_o, RESET_VEC);
    @(posedge clk);
    #2 reset = 0;
  endtask

  initial begin
    logic [31:0] exp_log[10];
    logic [31:0] tgt;
    reset = 1; halt = 0; id_ready = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_target = 0;
    m_reset();
    do_reset();

    // Sequential fetch, one-cycle memory.
    repeat (9) cyc(0, 1, 1, 0, 0);
    #2;
    chk("seq if_valid", if_valid, 1'b1);
    chk("seq if_pc", if_pc, 32'h0000_000C);
    chk("seq if_instr", if_instr, 32'hC0DE_000C);
    chk("seq pc_o", pc_o, 32'h0000_0010);

    // Decode stall holds the buffer and blocks requests.
    repeat (3) cyc(0, 0, 1, 0, 0);
    #2;
    chk("stall if_instr", if_instr, 32'hC0DE_000C);
    chk("stall if_valid", if_valid, 1'b1);
    chk("stall req count", acc_log.size(), 4);

    // Redirect during WAIT; the stale reply arrives two cycles later.
    min_dly = 3; max_dly = 3;
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 32'h0000_0040);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    #2;
    chk("kill if_valid", if_valid, 1'b0);
    chk("kill pc_o", pc_o, 32'h0000_0040);

    // Redirect with a full buffer flushes it.
    min_dly = 1; max_dly = 1;
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 32'h0000_0080);
    #2;
    chk("flush if_valid", if_valid, 1'b0);
    chk("flush pc_o", pc_o, 32'h0000_0080);

    // Halt during WAIT: reply still lands, no new request until release.
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    #2;
    chk("halt if_pc", if_pc, 32'h0000_0080);
    chk("halt if_instr", if_instr, 32'hC0DE_0080);
    repeat (2) cyc(1, 1, 1, 0, 0);
    #2;
    chk("halt req count", acc_log.size(), 7);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);

    // PC wraps past the top of the address space.
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    #2;
    chk("wrap pc_o", pc_o, 32'h0000_0000);
    chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);

    // Misaligned redirect.
    cyc(0, 1, 0, 1, 32'h0000_0042);
    #2;
`ifdef PC_TRAP_EN
    chk("mis pc_o", pc_o, TRAP_VEC);
    chk("mis trap_o", trap_o, 1'b1);
`else
    chk("mis pc_o", pc_o, 32'h0000_0040);
`endif
    cyc(0, 1, 1, 0, 0);
`ifdef PC_TRAP_EN
    #2;
    chk("mis trap_o clear", trap_o, 1'b0);
`endif

    exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h80, 32'h84, 32'hFFFF_FFFC,
`ifdef PC_TRAP_EN
                32'h100};
`else
                32'h40};
`endif
    chk("req log size", acc_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < acc_log.size()) chk($sformatf("req addr %0d", i), acc_log[i], exp_log[i]);
    end

    // Randomised traffic with occasional mid-flight resets and stray rvalid.
    use_pattern = 0; spur_en = 1; min_dly = 1; max_dly = 3;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(599, 0) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        else                           tgt = 32'($urandom_range(4095, 0));
        cyc($urandom_range(99, 0) < 15, $urandom_range(99, 0) < 70,
            $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 6, tgt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
